// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition controller.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_HOLDOFF   = 3'd3,
        ST_SWAP_WAIT = 3'd4
    } acq_state_t;

    localparam int CAP_DEPTH    = 256;
    localparam int VSWAP_LO_DEF = 10;
    localparam int VSWAP_HI_DEF = 500;
    localparam int TB_W         = 4;
    localparam int DIV_W        = 11;
    localparam logic [TB_W-1:0] TB_MAX = 4'd11;

    // Timebases past the divider width fall back to the slowest rate.
    function automatic logic [TB_W-1:0] clamp_tb(input logic [TB_W-1:0] tb);
        return (tb > TB_MAX) ? TB_MAX : tb;
    endfunction

endpackage

// File: rtl/sample_div.sv
// Free-running sample-rate divider: one strobe every 2^timebase cycles.
module sample_div
    import acq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TB_W-1:0] timebase_i,
    output logic            sample_en_o
);

    logic [DIV_W-1:0] div_q, div_d, lim;
    logic [TB_W-1:0]  tb_q;
    logic             wrap;
    logic             se_q;

    // The timebase is only picked up at a wrap so a period is never cut short.
    assign lim  = (DIV_W'(1) << tb_q) - DIV_W'(1);
    assign wrap = (div_q == lim);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (wrap) div_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            tb_q  <= '0;
            se_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            se_q  <= wrap;
            if (wrap) tb_q <= clamp_tb(timebase_i);
        end
    end

    assign sample_en_o = se_q;

endmodule

// File: rtl/acq_ctrl.sv
// Acquisition sequencer: arm/holdoff/Run-Stop-Single and tear-free frame swap.
// Define ACQ_AUTO_EN to build the auto-trigger timeout and force pulse.
module acq_ctrl
    import acq_pkg::*;
#(
    parameter int AUTO_TIMEOUT = 2_000_000,
    parameter int VSWAP_LO     = VSWAP_LO_DEF,
    parameter int VSWAP_HI     = VSWAP_HI_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            single,
    input  logic            auto_mode,
    input  logic [TB_W-1:0] timebase,
    input  logic [11:0]     holdoff,
    input  logic [10:0]     vcount,
    input  logic            cap_done,
    output logic            arm,
    output logic            force_o,
    output logic            sample_en,
    output logic            frame_swap,
    output logic [2:0]      state_o,
    output logic [15:0]     trig_cnt
);

    acq_state_t  state_q, state_d;
    logic        one_shot_q, one_shot_d;
    logic [11:0] hold_q, hold_d;
    logic [15:0] trig_cnt_q, trig_cnt_d;
    logic        arm_q, swap_q, swap_d;
    logic        swap_ok, hold_last;

    sample_div u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .timebase_i  (timebase),
        .sample_en_o (sample_en)
    );

    assign swap_ok   = (vcount < 11'(VSWAP_LO)) || (vcount > 11'(VSWAP_HI));
    // A zero holdoff still spends one cycle in HOLDOFF.
    assign hold_last = (holdoff == 12'd0) || (hold_q == holdoff - 12'd1);

    always_comb begin
        state_d    = state_q;
        one_shot_d = one_shot_q;
        hold_d     = '0;
        trig_cnt_d = trig_cnt_q;
        swap_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (single) begin
                    one_shot_d = 1'b1;
                    state_d    = ST_ARM;
                end else if (run) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: state_d = ST_WAIT_TRIG;
            ST_WAIT_TRIG: begin
                if (cap_done) begin
                    trig_cnt_d = trig_cnt_q + 16'd1;
                    state_d    = ST_SWAP_WAIT;
                end else if (!run && !one_shot_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWAP_WAIT: begin
                if (swap_ok) begin
                    swap_d  = 1'b1;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_last) begin
                    if (run && !one_shot_q) begin
                        state_d = ST_ARM;
                    end else begin
                        state_d    = ST_IDLE;
                        one_shot_d = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + 12'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            one_shot_q <= 1'b0;
            hold_q     <= '0;
            trig_cnt_q <= '0;
            arm_q      <= 1'b0;
            swap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            one_shot_q <= one_shot_d;
            hold_q     <= hold_d;
            trig_cnt_q <= trig_cnt_d;
            arm_q      <= (state_d == ST_WAIT_TRIG);
            swap_q     <= swap_d;
        end
    end

`ifdef ACQ_AUTO_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] to_q, to_d;
    logic            to_hit;

    assign to_hit = (to_q == TO_W'(AUTO_TIMEOUT - 1));

    // Saturating one past the hit value keeps the force strictly single-shot.
    always_comb begin
        to_d = to_q;
        if (state_q == ST_ARM) begin
            to_d = '0;
        end else if (state_q == ST_WAIT_TRIG && to_q != TO_W'(AUTO_TIMEOUT)) begin
            to_d = to_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end

    assign force_o = auto_mode && (state_q == ST_WAIT_TRIG) && to_hit && !cap_done
                     && (run || one_shot_q);
`else
    logic auto_mode_unused;
    assign auto_mode_unused = auto_mode;
    assign force_o          = 1'b0;
`endif

    assign arm        = arm_q;
    assign frame_swap = swap_q;
    assign state_o    = state_q;
    assign trig_cnt   = trig_cnt_q;

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed bench for acq_ctrl: modes, holdoff, swap window, timeout, wrap, reset.
module tb_acq_ctrl;

    logic        clk, rst_n, run, single, auto_mode, cap_done;
    logic [3:0]  timebase;
    logic [11:0] holdoff;
    logic [10:0] vcount;
    logic        arm, force_o, sample_en, frame_swap;
    logic [2:0]  state_o;
    logic [15:0] trig_cnt;

    int checks = 0;
    int errors = 0;
    int swap_seen = 0;
    int force_seen = 0;

    acq_ctrl #(.AUTO_TIMEOUT(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .single     (single),
        .auto_mode  (auto_mode),
        .timebase   (timebase),
        .holdoff    (holdoff),
        .vcount     (vcount),
        .cap_done   (cap_done),
        .arm        (arm),
        .force_o    (force_o),
        .sample_en  (sample_en),
        .frame_swap (frame_swap),
        .state_o    (state_o),
        .trig_cnt   (trig_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_swap) swap_seen++;
        if (force_o)    force_seen++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired before the directed sequence ended");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Skip the current strobe, lock onto the next, then count to the following one.
    task automatic measure(output int per);
        int n;
        n = 0;
        tick();
        while (!sample_en && n < 5000) begin tick(); n++; end
        tick();
        per = 1;
        while (!sample_en && per < 5000) begin tick(); per++; end
    endtask

    initial begin
        int per, hc, fcount, fidx, n, sw0;
        rst_n = 1'b0; run = 1'b0; single = 1'b0; auto_mode = 1'b0; cap_done = 1'b0;
        timebase = 4'd2; holdoff = 12'd5; vcount = 11'd0;
        tick(2);
        chk("rst_arm", arm, 0);
        chk("rst_force", force_o, 0);
        chk("rst_sample_en", sample_en, 0);
        chk("rst_swap", frame_swap, 0);
        chk("rst_state", state_o, 0);
        chk("rst_trig", trig_cnt, 0);
        rst_n = 1'b1;

        // run -> ARM -> WAIT_TRIG, arm two cycles after run
        run = 1'b1;
        tick();
        chk("arm_state1", state_o, 1);
        chk("arm_lo", arm, 0);
        tick();
        chk("arm_state2", state_o, 2);
        chk("arm_hi", arm, 1);

        measure(per); chk("tb2_period_a", per, 4);
        measure(per); chk("tb2_period_b", per, 4);
        timebase = 4'd0;
        measure(per); chk("tb0_period", per, 1);
        timebase = 4'd13;
        measure(per); chk("tb13_clamp_period", per, 2048);
        timebase = 4'd2;
        chk("no_force_normal", force_seen, 0);
        chk("still_wait", state_o, 2);

        // normal capture: swap held until vcount leaves the active window
        vcount = 11'd300;
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        chk("cap_state", state_o, 4);
        chk("cap_trig", trig_cnt, 1);
        chk("cap_arm_lo", arm, 0);
        tick(3);
        chk("swap_hold_state", state_o, 4);
        chk("swap_hold_none", swap_seen, 0);
        vcount = 11'd500;
        tick();
        chk("swap_500_blocked", state_o, 4);
        vcount = 11'd501;
        tick();
        chk("swap_pulse", frame_swap, 1);
        chk("swap_holdoff", state_o, 3);
        vcount = 11'd0;
        auto_mode = 1'b1;
        hc = 1;
        tick();
        chk("swap_one_cycle", frame_swap, 0);
        while (state_o == 3'd3 && hc < 100) begin hc++; tick(); end
        chk("holdoff_len", hc, 5);
        chk("rearm_state", state_o, 1);
        chk("swap_count1", swap_seen, 1);

        // auto mode: force once at WAIT_TRIG cycle 100
        tick();
        chk("auto_wait", state_o, 2);
        fcount = 0; fidx = 0;
        for (int k = 1; k <= 130; k++) begin
            if (force_o) begin fcount++; fidx = k; end
            tick();
        end
`ifdef ACQ_AUTO_EN
        chk("force_count", fcount, 1);
        chk("force_cycle", fidx, 100);
`else
        chk("force_tied_off", fcount, 0);
`endif
        chk("auto_still_wait", state_o, 2);
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        chk("auto_cap_state", state_o, 4);
        chk("auto_cap_trig", trig_cnt, 2);
        tick();
        chk("auto_swap", frame_swap, 1);
        auto_mode = 1'b0;

        // stop, then single shot with a second single ignored mid-capture
        run = 1'b0;
        n = 0;
        while (state_o != 3'd0 && n < 50) begin tick(); n++; end
        chk("stop_idle", state_o, 0);
        tick(3);
        chk("stop_stays_idle", state_o, 0);
        single = 1'b1; tick(); single = 1'b0;
        chk("single_arm", state_o, 1);
        tick();
        chk("single_arm_hi", arm, 1);
        tick(3);
        chk("single_holds_wait", state_o, 2);
        single = 1'b1; tick(); single = 1'b0;
        chk("single_ignored", state_o, 2);
        vcount = 11'd10;
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        chk("single_trig", trig_cnt, 3);
        tick(2);
        chk("swap_10_blocked", state_o, 4);
        vcount = 11'd9;
        tick();
        chk("single_swap", frame_swap, 1);
        n = 0;
        while (state_o == 3'd3 && n < 50) begin tick(); n++; end
        chk("single_end_idle", state_o, 0);
        tick(4);
        chk("single_no_rearm", state_o, 0);
        chk("single_trig_final", trig_cnt, 3);
        vcount = 11'd0;

        // run dropped in WAIT_TRIG: no capture, no swap
        run = 1'b1;
        tick(2);
        chk("drop_arm_hi", arm, 1);
        sw0 = swap_seen;
        run = 1'b0;
        tick();
        chk("drop_arm_lo", arm, 0);
        chk("drop_idle", state_o, 0);
        tick(5);
        chk("drop_no_swap", swap_seen, sw0);
        chk("drop_trig", trig_cnt, 3);

        // async reset in HOLDOFF while frame_swap is high
        holdoff = 12'd20;
        run = 1'b1;
        tick(2);
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        tick();
        chk("pre_rst_swap", frame_swap, 1);
        chk("pre_rst_holdoff", state_o, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_swap", frame_swap, 0);
        chk("arst_arm", arm, 0);
        chk("arst_force", force_o, 0);
        chk("arst_state", state_o, 0);
        chk("arst_trig", trig_cnt, 0);
        chk("arst_sample_en", sample_en, 0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // trig_cnt wrap from 0xFFFF, with the one-cycle zero holdoff
        force dut.trig_cnt_q = 16'hFFFF;
        tick();
        release dut.trig_cnt_q;
        tick();
        chk("preload", trig_cnt, 16'hFFFF);
        holdoff = 12'd0;
        run = 1'b1;
        tick(2);
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        chk("wrap_trig", trig_cnt, 0);
        tick();
        chk("wrap_holdoff", state_o, 3);
        tick();
        chk("holdoff0_rearm", state_o, 1);
        run = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_ctrl.md
# acq_ctrl

Acquisition controller for the oscilloscope capture path. It sequences the level-trigger/capture engine: generates the sample-rate strobe, arms and disarms the engine, applies holdoff and auto-trigger timeout, and implements Run/Stop/Single modes. It publishes a completed 256-sample frame to the display side only during vertical blanking, so the waveform never tears mid-frame.

## Interface
Parameters:
- `AUTO_TIMEOUT`, default 2_000_000: clock cycles in WAIT_TRIG before a forced capture in auto mode.
- `VSWAP_LO`, default 10: a swap is allowed when `vcount < VSWAP_LO`.
- `VSWAP_HI`, default 500: a swap is allowed when `vcount > VSWAP_HI`.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level. 1 = continuous acquisition, 0 = stop.
- `single` in 1: one-cycle pulse. Requests exactly one capture.
- `auto_mode` in 1: 1 = auto trigger, 0 = normal trigger.
- `timebase` in 4: sample strobe period is 2^timebase cycles. Valid values 0..11; values of 12 and above clamp to 11.
- `holdoff` in 12: idle cycles after each capture before re-arming.
- `vcount` in 11: display vertical counter.
- `cap_done` in 1: one-cycle pulse from the capture engine when 256 samples are stored.
- `arm` out 1: engine may search for a trigger and capture.
- `force` out 1: one-cycle pulse commanding an immediate untriggered capture.
- `sample_en` out 1: one-cycle sample strobe.
- `frame_swap` out 1: one-cycle pulse; the display copies the capture buffer on this pulse.
- `state_o` out 3: current state encoding.
- `trig_cnt` out 16: number of completed captures; wraps.

## Operation
- States: IDLE(0), ARM(1), WAIT_TRIG(2), HOLDOFF(3), SWAP_WAIT(4).
- IDLE → ARM when `run`=1 or `single` is pulsed. A `single` pulse sets the `one_shot` flag.
- ARM: lasts one cycle, then → WAIT_TRIG. The timeout counter clears.
- WAIT_TRIG: `arm`=1.
  - On `cap_done`: `trig_cnt`++, then → SWAP_WAIT.
  - Auto mode: when the timeout counter reaches `AUTO_TIMEOUT-1`, pulse `force` once. The state stays WAIT_TRIG until `cap_done`.
- SWAP_WAIT: waits for vcount to satisfy `vcount<VSWAP_LO || vcount>VSWAP_HI`. Then pulse `frame_swap` and → HOLDOFF.
- HOLDOFF: counts `holdoff` cycles.
  - A `holdoff` value of 0 means exit after 1 cycle.
  - Exit to ARM if `run`=1 and `one_shot`=0. Otherwise exit to IDLE and clear `one_shot`.
- `run` falling in WAIT_TRIG: drop `arm` and → IDLE. A partial capture is discarded and no swap occurs.
  - Exception: if `one_shot`=1, the capture continues to completion.
- `single` outside IDLE is ignored.
- `sample_en`:
  - Driven by a free-running 11-bit divider. It pulses when `div_cnt == (1<<tb)-1`, then the divider resets to 0.
  - For tb=0 it is high every cycle.
  - It runs in all states.
- `trig_cnt` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values of all outputs are 0. Internally: state IDLE, all counters 0, `one_shot`=0.
- `arm` is registered. It rises in the cycle after the ARM state and falls in the cycle after `cap_done` is sampled.
- `frame_swap` has 1 cycle of latency from the first qualifying `vcount` sample seen in SWAP_WAIT.
- `cap_done` and a timeout in the same cycle: `cap_done` wins and `force` is not issued.
- A `timebase` change takes effect on the next divider wrap.
- Assertion of `rst_n` mid-capture immediately drops `arm`, `force`, and `frame_swap`.

## Configuration
- `ACQ_AUTO_EN` defined: the timeout counter, `force` generation, and `auto_mode` are active.
- `ACQ_AUTO_EN` not defined: no timeout counter is synthesised, `force` is tied to 0, and `auto_mode` is ignored (normal mode only).

## Structure
- Package `acq_pkg`:
  - `acq_state_t` enum with the encodings above.
  - Constant `CAP_DEPTH` = 256.
  - Default `VSWAP_LO` and `VSWAP_HI` values.
- Sub-module `sample_div`: owns the timebase divider and produces `sample_en`. The FSM and all counters stay in `acq_ctrl`.

## Test plan
- Reset, then `run`=1, tb=2: `sample_en` pulses every 4 cycles. `arm` rises 2 cycles after `run`.
- Normal mode, with `cap_done` pulsed while `vcount`=300: `frame_swap` is held until `vcount`=501, then pulses once. `trig_cnt`=1 and HOLDOFF lasts `holdoff`=5 cycles before re-arm.
- Auto mode with `AUTO_TIMEOUT`=100 and no `cap_done`: `force` pulses exactly once at cycle 100 of WAIT_TRIG. A later `cap_done` completes the frame normally.
- `run`=0 plus a `single` pulse: exactly one capture and swap occur, then IDLE. A second `single` issued mid-capture is ignored.
- `run` dropped mid-WAIT_TRIG (not single): `arm` falls next cycle and there is no `frame_swap`. Then `rst_n` is pulsed low asynchronously mid-HOLDOFF: all outputs are 0 immediately and the state is IDLE.
- Preload `trig_cnt`=0xFFFF via 65535 captures (or force): the next capture wraps `trig_cnt` to 0.
